uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Synthesizable 8N1 UART transmitter with an input byte FIFO. It is the upstream stage that drives the serial line sampled by the UART receiver at 9600 baud.
- Host logic pushes bytes; the block serialises them LSB first as start bit, 8 data bits, stop bit.
- Bytes go out back-to-back with no idle gap while the FIFO holds data.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s. CLKS_PER_BIT = CLK_FREQ/BAUD, integer division truncating (5208 at defaults). CLKS_PER_BIT must be >= 2.
- FIFO_DEPTH, 8, byte entries. Power of two, >= 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- wr_data  in  8  byte to enqueue.
- wr_en  in  1  enqueue request; qualified by !full.
- full  out  1  FIFO holds FIFO_DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- tx  out  1  serial line, idle high.
- busy  out  1  high while a frame is on the line (states START, DATA, STOP).
- overflow  out  1  one-cycle pulse when wr_en is asserted while full.

Behaviour:
- Reset (rst high at an edge): FIFO count, rd_ptr and wr_ptr = 0; state = IDLE; baud counter and bit index = 0.
- Outputs after that edge: tx=1, busy=0, full=0, empty=1, overflow=0. Takes priority over everything.
- Reset mid-frame aborts the frame; tx is high after the reset edge. Queued bytes are discarded.
- FIFO write: the byte is stored when wr_en=1 and registered full=0.
- Write while full: data is dropped, FIFO is unchanged, and overflow=1 for exactly the next cycle. This holds even if a pop occurs on the same edge.
- FIFO pop: internal, performed only by the FSM.
- Simultaneous write and pop: both happen and the count is unchanged.
- Pointers wrap modulo FIFO_DEPTH. full and empty are registered, derived from the next count.
- Baud counter: counts 0..CLKS_PER_BIT-1. Each line bit lasts exactly CLKS_PER_BIT clocks.
- FSM states:
  - IDLE: tx=1. If empty=0, pop the head byte into the shift register and go to START; the counter restarts at 0.
  - START: tx=0 for CLKS_PER_BIT clocks, then go to DATA with bit index 0.
  - DATA: tx=shift[bit index] for CLKS_PER_BIT clocks per bit. After bit 7 go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT clocks. On the last stop cycle:
    - if empty=0, pop and go directly to START (next frame starts with no gap);
    - else go to IDLE.
- Frame length: exactly 10*CLKS_PER_BIT clocks. Back-to-back frames are spaced exactly 10*CLKS_PER_BIT.
- Latency: wr_en sampled at edge k into an empty FIFO while IDLE. Then:
  - empty falls after edge k;
  - the FSM pops and tx falls after edge k+1;
  - empty returns high after edge k+1 if no further write occurs.
- tx is a register output; no combinational path from any input to tx.
- Bytes are transmitted in write order. Writes during a frame do not disturb it.

Test Plan:
- Reset and idle: CLK_FREQ=160, BAUD=10 (CLKS_PER_BIT=16). Hold rst for 3 cycles, then release. Required: tx=1, busy=0, empty=1, full=0, overflow=0 for 50 cycles.
- Single byte: write 8'hA5 at edge k. Required: tx low from edge k+1 for 16 clocks. Then bits 1,0,1,0,0,1,0,1 for 16 clocks each, then high for 16. busy falls after edge k+161. A bit-level line monitor decodes 8'hA5.
- Back-to-back: write 8'h00, 8'hFF, 8'h3C on consecutive cycles. Required: three frames with start edges exactly 160 clocks apart, decoded in order 00, FF, 3C. After the last stop bit: empty=1.
- Full/overflow with FIFO_DEPTH=4: write 8'h10 at edge 0, then 8'h11..8'h15 on consecutive edges. Required:
  - 8'h10 is popped after edge 1 and 8'h11..8'h14 fill the FIFO; full=1 after the 8'h14 write;
  - the 8'h15 write gives a one-cycle overflow pulse and is dropped;
  - line output is exactly 10,11,12,13,14.
- Reset mid-frame: write 8'h5A and assert rst in the middle of data bit 3. Required: tx=1 after the reset edge, empty=1, no further frame. A later write of 8'h81 transmits cleanly.
- Simultaneous write and pop: FIFO holds 8'h01. Write 8'h02 on the edge where the STOP→START pop occurs. Required: count unchanged, 8'h02 transmitted next with no gap.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// Host-side bus of the UART transmitter: byte enqueue handshake, FIFO
// status flags and the serial line itself.
interface uart_tx_fifo_if;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       full;
  logic       empty;
  logic       tx;
  logic       busy;
  logic       overflow;

  // Host side: pushes bytes, observes status and the line
  modport master (
    output wr_data,
    output wr_en,
    input  full,
    input  empty,
    input  tx,
    input  busy,
    input  overflow
  );

  // Transmitter side
  modport slave (
    input  wr_data,
    input  wr_en,
    output full,
    output empty,
    output tx,
    output busy,
    output overflow
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a byte FIFO. Frames are sent LSB first
// (start, 8 data, stop) and follow each other with no idle gap while
// the FIFO holds data. All outputs are registered.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_fifo_if.slave  bus
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PTR_W        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  // FIFO storage and bookkeeping
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic [PTR_W:0]   count_d;
  logic             full_q;
  logic             empty_q;
  logic             overflow_q;

  // Serialiser state
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             tx_q;
  logic             busy_q;

  logic             push;
  logic             pop;
  logic             bit_done;

  // A write is accepted only against the registered full flag, so a pop on
  // the same edge never frees room for a write that was already refused.
  assign push     = bus.wr_en && !full_q;
  assign bit_done = (cnt_q == CNT_LAST);

  // Pop the head byte when idle with data, or on the last stop-bit cycle
  // so the next start bit follows without a gap.
  always_comb begin
    pop = 1'b0;
    unique case (state_q)
      S_IDLE:  pop = !empty_q;
      S_STOP:  pop = bit_done && !empty_q;
      default: pop = 1'b0;
    endcase
  end

  // Next occupancy; simultaneous push and pop leave it unchanged
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage write; data array carries no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.wr_data;
    end
  end

  // FIFO pointers, occupancy and registered status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q    <= count_d;
      full_q     <= (count_d == CNT_FULL);
      empty_q    <= (count_d == '0);
      overflow_q <= bus.wr_en && full_q;
    end
  end

  // Load the shift register with the byte being popped
  always_ff @(posedge clk) begin
    if (pop) begin
      shift_q <= mem_q[rd_ptr_q];
    end
  end

  // Frame sequencer with registered line and busy outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          cnt_q  <= '0;
          if (pop) begin
            state_q <= S_START;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          if (bit_done) begin
            state_q   <= S_DATA;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            tx_q      <= shift_q[0];
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (bit_done) begin
            cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              state_q <= S_STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= shift_q[bit_idx_q + 3'd1];
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (bit_done) begin
            cnt_q <= '0;
            if (pop) begin
              state_q <= S_START;
              tx_q    <= 1'b0;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.full     = full_q;
  assign bus.empty    = empty_q;
  assign bus.tx       = tx_q;
  assign bus.busy     = busy_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at 16 clocks per bit, 4-entry FIFO.
module tb_uart_tx_fifo;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   cyc;

  uart_tx_fifo_if bus ();

  uart_tx_fifo #(
    .CLK_FREQ  (160),
    .BAUD      (10),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Advance past the next rising edge; inputs are driven and outputs sampled here
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Line checker for one frame; sample i is taken i clocks after the edge
  // that drove the start bit low. Also decodes the byte at bit centres.
  task automatic check_frame(input logic [7:0] exp, input int first_i, input int last_i);
    logic [7:0] dec;
    logic       exp_bit;
    int         b;
    dec = 8'h00;
    for (int i = first_i; i <= last_i; i++) begin
      b = i / 16;
      if (b == 0)      exp_bit = 1'b0;
      else if (b == 9) exp_bit = 1'b1;
      else             exp_bit = exp[b-1];
      n_checks++;
      if (bus.tx !== exp_bit) begin
        n_fail++;
        $display("FAIL frame_tx: byte %h sample %0d got %b, required %b", exp, i, bus.tx, exp_bit);
      end
      n_checks++;
      if (bus.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL frame_busy: byte %h sample %0d got %b, required 1", exp, i, bus.busy);
      end
      if (b >= 1 && b <= 8 && (i % 16) == 8) dec[b-1] = bus.tx;
      tick();
    end
    if (first_i <= 24 && last_i >= 136) begin
      n_checks++;
      if (dec !== exp) begin
        n_fail++;
        $display("FAIL frame_decode: got %h, required %h", dec, exp);
      end
    end
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    repeat (3) tick();
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("reset_tx", 32'(bus.tx), 32'd1);
      chk("reset_busy", 32'(bus.busy), 32'd0);
      chk("reset_empty", 32'(bus.empty), 32'd1);
      chk("reset_full", 32'(bus.full), 32'd0);
      chk("reset_overflow", 32'(bus.overflow), 32'd0);
    end
  endtask

  task automatic test_single_byte();
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'hA5;
    tick();                       // edge k
    bus.wr_en = 1'b0;
    chk("single_empty_k", 32'(bus.empty), 32'd0);
    chk("single_tx_k", 32'(bus.tx), 32'd1);
    chk("single_busy_k", 32'(bus.busy), 32'd0);
    tick();                       // edge k+1
    chk("single_empty_k1", 32'(bus.empty), 32'd1);
    check_frame(8'hA5, 0, 159);   // ends after edge k+161
    chk("single_busy_end", 32'(bus.busy), 32'd0);
    chk("single_tx_end", 32'(bus.tx), 32'd1);
    tick();
  endtask

  task automatic test_back_to_back();
    int s0, s1, s2;
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'h00;
    tick();                       // edge k
    bus.wr_data = 8'hFF;
    tick();                       // edge k+1: first start bit
    s0 = cyc;
    chk("b2b_start0", 32'(bus.tx), 32'd0);
    bus.wr_data = 8'h3C;
    tick();                       // edge k+2
    bus.wr_en = 1'b0;
    check_frame(8'h00, 1, 159);
    s1 = cyc;
    chk("b2b_spacing01", 32'(s1 - s0), 32'd160);
    check_frame(8'hFF, 0, 159);
    s2 = cyc;
    chk("b2b_spacing12", 32'(s2 - s1), 32'd160);
    check_frame(8'h3C, 0, 159);
    chk("b2b_empty_end", 32'(bus.empty), 32'd1);
    chk("b2b_busy_end", 32'(bus.busy), 32'd0);
    chk("b2b_tx_end", 32'(bus.tx), 32'd1);
    tick();
  endtask

  task automatic test_overflow();
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'h10;
    tick();                       // edge 0
    bus.wr_data = 8'h11;
    tick();                       // edge 1: 8'h10 popped
    chk("ovf_start", 32'(bus.tx), 32'd0);
    chk("ovf_busy", 32'(bus.busy), 32'd1);
    bus.wr_data = 8'h12;
    tick();                       // edge 2
    bus.wr_data = 8'h13;
    tick();                       // edge 3
    chk("ovf_full_3", 32'(bus.full), 32'd0);
    chk("ovf_ovf_3", 32'(bus.overflow), 32'd0);
    bus.wr_data = 8'h14;
    tick();                       // edge 4
    chk("ovf_full_4", 32'(bus.full), 32'd1);
    chk("ovf_ovf_4", 32'(bus.overflow), 32'd0);
    bus.wr_data = 8'h15;
    tick();                       // edge 5: write while full
    chk("ovf_pulse", 32'(bus.overflow), 32'd1);
    chk("ovf_full_5", 32'(bus.full), 32'd1);
    bus.wr_en = 1'b0;
    tick();                       // edge 6
    chk("ovf_pulse_end", 32'(bus.overflow), 32'd0);
    check_frame(8'h10, 5, 159);
    check_frame(8'h11, 0, 159);
    check_frame(8'h12, 0, 159);
    check_frame(8'h13, 0, 159);
    check_frame(8'h14, 0, 159);
    chk("ovf_busy_end", 32'(bus.busy), 32'd0);
    chk("ovf_tx_end", 32'(bus.tx), 32'd1);
    chk("ovf_empty_end", 32'(bus.empty), 32'd1);
    tick();
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'h5A;
    tick();                       // edge k
    bus.wr_data = 8'h66;          // queued behind the aborted frame
    tick();                       // edge k+1: start bit
    bus.wr_en = 1'b0;
    check_frame(8'h5A, 0, 71);    // now in the middle of data bit 3
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_tx", 32'(bus.tx), 32'd1);
    chk("rstmid_busy", 32'(bus.busy), 32'd0);
    chk("rstmid_empty", 32'(bus.empty), 32'd1);
    chk("rstmid_full", 32'(bus.full), 32'd0);
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0) bad++;
    end
    chk("rstmid_quiet_cycles_bad", 32'(bad), 32'd0);
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'h81;
    tick();
    bus.wr_en = 1'b0;
    tick();
    check_frame(8'h81, 0, 159);
    chk("rstmid_busy_end", 32'(bus.busy), 32'd0);
    tick();
  endtask

  task automatic test_simul_write_pop();
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'hC3;
    tick();                       // edge k
    bus.wr_data = 8'h01;
    tick();                       // edge k+1: C3 popped, 01 queued
    bus.wr_en = 1'b0;
    check_frame(8'hC3, 0, 158);   // at last stop-bit cycle
    chk("sim_stop_tx", 32'(bus.tx), 32'd1);
    chk("sim_empty_pre", 32'(bus.empty), 32'd0);
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'h02;
    tick();                       // pop 01 and push 02 together
    bus.wr_en = 1'b0;
    chk("sim_empty_post", 32'(bus.empty), 32'd0);
    chk("sim_full_post", 32'(bus.full), 32'd0);
    check_frame(8'h01, 0, 159);   // 02 popped on the last edge
    chk("sim_empty_after_pop", 32'(bus.empty), 32'd1);
    check_frame(8'h02, 0, 159);
    chk("sim_busy_end", 32'(bus.busy), 32'd0);
    chk("sim_tx_end", 32'(bus.tx), 32'd1);
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_overflow();
    test_reset_mid_frame();
    test_simul_write_pop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
